// File: rtl/yolo_pkg.sv
// Shared YOLO datapath definitions: FP32 width, signed zeros and the
// sign-magnitude ordering used by the pooling stages.
package yolo_pkg;

    localparam int unsigned FP32_WIDTH = 32;

    localparam logic [FP32_WIDTH-1:0] FP32_POS_ZERO = 32'h0000_0000;
    localparam logic [FP32_WIDTH-1:0] FP32_NEG_ZERO = 32'h8000_0000;

    // Strict a > b under sign-magnitude ordering; +0 and -0 compare equal.
    function automatic logic fp32_gt(input logic [FP32_WIDTH-1:0] a,
                                     input logic [FP32_WIDTH-1:0] b);
        logic a_zero;
        logic b_zero;
        a_zero = ((a & ~FP32_NEG_ZERO) == FP32_POS_ZERO);
        b_zero = ((b & ~FP32_NEG_ZERO) == FP32_POS_ZERO);
        if (a_zero && b_zero) begin
            return 1'b0;
        end
        if (a[FP32_WIDTH-1] != b[FP32_WIDTH-1]) begin
            return b[FP32_WIDTH-1];
        end
        if (a[FP32_WIDTH-1]) begin
            return (a[FP32_WIDTH-2:0] < b[FP32_WIDTH-2:0]);
        end
        return (a[FP32_WIDTH-2:0] > b[FP32_WIDTH-2:0]);
    endfunction

endpackage

// File: rtl/fp32_max.sv
// Combinational FP32 max; on a tie the earlier operand (a) is kept.
module fp32_max
    import yolo_pkg::*;
(
    input  logic [FP32_WIDTH-1:0] a,
    input  logic [FP32_WIDTH-1:0] b,
    output logic [FP32_WIDTH-1:0] y
);

    always_comb begin
        y = fp32_gt(b, a) ? b : a;
    end

endmodule

// File: rtl/layer_0_maxpool_2x2.sv
// Streaming 2x2 stride-2 max-pool for YOLOv3-Tiny layer 0; one half-width
// line of partial maxima, no backpressure. IMG_SIZE must be even and >= 4.
module layer_0_maxpool_2x2
    import yolo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FP32_WIDTH,
    parameter int unsigned IMG_SIZE   = 416
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  last_out
);

    localparam int unsigned HALF = IMG_SIZE / 2;
    localparam int unsigned CW   = $clog2(IMG_SIZE);
    localparam logic [CW-1:0] LAST = CW'(IMG_SIZE - 1);

    logic [CW-1:0]         col_q;
    logic [CW-1:0]         row_q;
    logic [DATA_WIDTH-1:0] h_q;
    logic [DATA_WIDTH-1:0] lb [HALF];
    logic [CW-2:0]         lb_addr;
    logic [DATA_WIDTH-1:0] lb_rd;
    logic [DATA_WIDTH-1:0] pair_max;
    logic [DATA_WIDTH-1:0] pool_max;
    logic                  pair_done;

    assign lb_addr   = col_q[CW-1:1];
    assign lb_rd     = lb[lb_addr];
    assign pair_done = valid_in && col_q[0];

    fp32_max u_pair_max (
        .a (h_q),
        .b (data_in),
        .y (pair_max)
    );

    // The line-buffer entry came from the row above, so it is the earlier operand.
    fp32_max u_vert_max (
        .a (lb_rd),
        .b (pair_max),
        .y (pool_max)
    );

    // Even rows only write, odd rows only read: no read/write address collision.
    always_ff @(posedge clk) begin
        if (pair_done && !row_q[0]) begin
            lb[lb_addr] <= pair_max;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q     <= '0;
            row_q     <= '0;
            h_q       <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            last_out  <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            last_out  <= 1'b0;
            if (valid_in) begin
                if (!col_q[0]) begin
                    h_q <= data_in;
                end else if (row_q[0]) begin
                    data_out  <= pool_max;
                    valid_out <= 1'b1;
                    last_out  <= (row_q == LAST) && (col_q == LAST);
                end
                if (col_q == LAST) begin
                    col_q <= '0;
                    row_q <= (row_q == LAST) ? '0 : row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
        end
    end

endmodule
